// File: rtl/atom_config_loader.sv
// rtl/atom_config_loader.sv - shadow/active configuration bank loader for the paired stateful atom
// Optional shadow readback port: define ATOM_CFG_READBACK_EN.
module atom_config_loader #(
    parameter int NUM_CONS  = 20,
    parameter int NUM_SEL   = 36,
    parameter int NUM_REL   = 4,
    parameter int NUM_ARITH = 8,
    parameter int ADDR_W    = 7
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i__cfg_valid,
    output logic                      o__cfg_ready,
    input  logic [ADDR_W-1:0]         i__cfg_addr,
    input  logic [31:0]               i__cfg_data,
    input  logic                      i__commit,
    input  logic                      i__pkt_valid,
`ifdef ATOM_CFG_READBACK_EN
    input  logic [ADDR_W-1:0]         i__rd_addr,
    output logic [31:0]               o__rd_data,
`endif
    output logic [NUM_CONS*32-1:0]    o__cons,
    output logic [NUM_SEL*2-1:0]      o__sel,
    output logic [NUM_REL*2-1:0]      o__rel_op,
    output logic [NUM_ARITH-1:0]      o__arith_op,
    output logic                      o__busy,
    output logic                      o__err,
    output logic [7:0]                o__cfg_gen
);

    localparam int SEL_BASE   = NUM_CONS;
    localparam int REL_BASE   = SEL_BASE + NUM_SEL;
    localparam int ARITH_BASE = REL_BASE + NUM_REL;
    localparam int NUM_WORDS  = ARITH_BASE + NUM_ARITH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    state_t state_q;

    logic [31:0]          cons_sh_q  [NUM_CONS];
    logic [1:0]           sel_sh_q   [NUM_SEL];
    logic [1:0]           rel_sh_q   [NUM_REL];
    logic [NUM_ARITH-1:0] arith_sh_q;

    logic [31:0]          cons_act_q [NUM_CONS];
    logic [1:0]           sel_act_q  [NUM_SEL];
    logic [1:0]           rel_act_q  [NUM_REL];
    logic [NUM_ARITH-1:0] arith_act_q;

    logic [NUM_CONS*32-1:0] cons_out_q;
    logic [NUM_SEL*2-1:0]   sel_out_q;
    logic [NUM_REL*2-1:0]   rel_out_q;
    logic [NUM_ARITH-1:0]   arith_out_q;
    logic                   busy_q;
    logic                   ready_q;
    logic                   err_q;
    logic [7:0]             gen_q;

    logic wr_acc;
    int   wr_addr;

    assign wr_acc  = i__cfg_valid & ready_q;
    assign wr_addr = int'({{(32-ADDR_W){1'b0}}, i__cfg_addr});

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
            err_q       <= 1'b0;
            gen_q       <= 8'd0;
            arith_sh_q  <= '0;
            arith_act_q <= '0;
            cons_out_q  <= '0;
            sel_out_q   <= '0;
            rel_out_q   <= '0;
            arith_out_q <= '0;
            for (int k = 0; k < NUM_CONS; k++) begin
                cons_sh_q[k]  <= '0;
                cons_act_q[k] <= '0;
            end
            for (int k = 0; k < NUM_SEL; k++) begin
                sel_sh_q[k]  <= '0;
                sel_act_q[k] <= '0;
            end
            for (int k = 0; k < NUM_REL; k++) begin
                rel_sh_q[k]  <= '0;
                rel_act_q[k] <= '0;
            end
        end else begin
            // Shadow writes; out-of-range addresses are swallowed and flagged.
            for (int k = 0; k < NUM_CONS; k++)
                if (wr_acc && wr_addr == k) cons_sh_q[k] <= i__cfg_data;
            for (int k = 0; k < NUM_SEL; k++)
                if (wr_acc && wr_addr == SEL_BASE + k) sel_sh_q[k] <= i__cfg_data[1:0];
            for (int k = 0; k < NUM_REL; k++)
                if (wr_acc && wr_addr == REL_BASE + k) rel_sh_q[k] <= i__cfg_data[1:0];
            for (int k = 0; k < NUM_ARITH; k++)
                if (wr_acc && wr_addr == ARITH_BASE + k) arith_sh_q[k] <= i__cfg_data[0];
            if (wr_acc && wr_addr >= NUM_WORDS) err_q <= 1'b1;

            case (state_q)
                ST_PEND: begin
                    if (!i__pkt_valid) begin
                        cons_act_q  <= cons_sh_q;
                        sel_act_q   <= sel_sh_q;
                        rel_act_q   <= rel_sh_q;
                        arith_act_q <= arith_sh_q;
                        gen_q       <= gen_q + 8'd1;
                        state_q     <= ST_IDLE;
                        busy_q      <= 1'b0;
                        ready_q     <= 1'b1;
                    end
                end
                default: begin
                    if (i__commit) begin
                        state_q <= ST_PEND;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                    end else if (wr_acc) begin
                        state_q <= ST_LOAD;
                    end
                end
            endcase

            // Output stage re-registers the active bank, so the swap shows one cycle later.
            for (int k = 0; k < NUM_CONS; k++) cons_out_q[32*k +: 32] <= cons_act_q[k];
            for (int k = 0; k < NUM_SEL; k++)  sel_out_q[2*k +: 2]    <= sel_act_q[k];
            for (int k = 0; k < NUM_REL; k++)  rel_out_q[2*k +: 2]    <= rel_act_q[k];
            arith_out_q <= arith_act_q;
        end
    end

`ifdef ATOM_CFG_READBACK_EN
    logic [31:0] rd_word;
    logic [31:0] rd_data_q;
    int          rd_addr;

    assign rd_addr = int'({{(32-ADDR_W){1'b0}}, i__rd_addr});

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NUM_CONS; k++)
            if (rd_addr == k) rd_word = cons_sh_q[k];
        for (int k = 0; k < NUM_SEL; k++)
            if (rd_addr == SEL_BASE + k) rd_word = {30'd0, sel_sh_q[k]};
        for (int k = 0; k < NUM_REL; k++)
            if (rd_addr == REL_BASE + k) rd_word = {30'd0, rel_sh_q[k]};
        for (int k = 0; k < NUM_ARITH; k++)
            if (rd_addr == ARITH_BASE + k) rd_word = {31'd0, arith_sh_q[k]};
    end

    always_ff @(posedge clk) begin
        if (rst) rd_data_q <= '0;
        else     rd_data_q <= rd_word;
    end

    assign o__rd_data = rd_data_q;
`endif

    assign o__cfg_ready = ready_q;
    assign o__cons      = cons_out_q;
    assign o__sel       = sel_out_q;
    assign o__rel_op    = rel_out_q;
    assign o__arith_op  = arith_out_q;
    assign o__busy      = busy_q;
    assign o__err       = err_q;
    assign o__cfg_gen   = gen_q;

endmodule

// File: tb/tb_atom_config_loader.sv
// tb/tb_atom_config_loader.sv - self-checking bench for atom_config_loader
// Expected active banks are pushed at each commit and popped when the outputs settle.
module tb_atom_config_loader;

    localparam int NUM_CONS  = 20;
    localparam int NUM_SEL   = 36;
    localparam int NUM_REL   = 4;
    localparam int NUM_ARITH = 8;
    localparam int ADDR_W    = 7;

    typedef struct packed {
        logic [NUM_CONS*32-1:0] cons;
        logic [NUM_SEL*2-1:0]   sel;
        logic [NUM_REL*2-1:0]   rel;
        logic [NUM_ARITH-1:0]   arith;
        logic [7:0]             gen;
    } snap_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   cfg_valid;
    logic                   cfg_ready;
    logic [ADDR_W-1:0]      cfg_addr;
    logic [31:0]            cfg_data;
    logic                   commit;
    logic                   pkt_valid;
    logic [NUM_CONS*32-1:0] cons;
    logic [NUM_SEL*2-1:0]   sel;
    logic [NUM_REL*2-1:0]   rel_op;
    logic [NUM_ARITH-1:0]   arith_op;
    logic                   busy;
    logic                   err;
    logic [7:0]             cfg_gen;
`ifdef ATOM_CFG_READBACK_EN
    logic [ADDR_W-1:0]      rd_addr = '0;
    logic [31:0]            rd_data;
`endif

    int checks   = 0;
    int failures = 0;

    snap_t m;
    snap_t cur;
    snap_t exp_q[$];

    always #5 clk = ~clk;

    atom_config_loader dut (
        .clk          (clk),
        .rst          (rst),
        .i__cfg_valid (cfg_valid),
        .o__cfg_ready (cfg_ready),
        .i__cfg_addr  (cfg_addr),
        .i__cfg_data  (cfg_data),
        .i__commit    (commit),
        .i__pkt_valid (pkt_valid),
`ifdef ATOM_CFG_READBACK_EN
        .i__rd_addr   (rd_addr),
        .o__rd_data   (rd_data),
`endif
        .o__cons      (cons),
        .o__sel       (sel),
        .o__rel_op    (rel_op),
        .o__arith_op  (arith_op),
        .o__busy      (busy),
        .o__err       (err),
        .o__cfg_gen   (cfg_gen)
    );

    task automatic chk(input string tag, input logic [699:0] obs, input logic [699:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_write(input int a, input logic [31:0] d);
        if (a < 20)       m.cons[32*a +: 32]     = d;
        else if (a < 56)  m.sel[2*(a-20) +: 2]   = d[1:0];
        else if (a < 60)  m.rel[2*(a-56) +: 2]   = d[1:0];
        else if (a < 68)  m.arith[a-60]          = d[0];
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        cfg_valid = 1'b1;
        cfg_addr  = ADDR_W'(a);
        cfg_data  = d;
        model_write(a, d);
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic push_commit();
        m.gen = m.gen + 8'd1;
        exp_q.push_back(m);
    endtask

    task automatic chk_unchanged(input string tag);
        chk({tag, "_cons"},  cons,     cur.cons);
        chk({tag, "_sel"},   sel,      cur.sel);
        chk({tag, "_rel"},   rel_op,   cur.rel);
        chk({tag, "_arith"}, arith_op, cur.arith);
    endtask

    // Waits out PEND (bounded), then checks the gen counter and the settled active outputs.
    task automatic finish_commit(input string tag, input int exp_pend_cycles);
        snap_t e;
        int n = 0;
        while (busy && n < 20) begin
            chk({tag, "_ready_low"}, cfg_ready, 1'b0);
            chk_unchanged({tag, "_hold"});
            tick();
            n++;
        end
        chk({tag, "_pend_bound"}, busy, 1'b0);
        if (exp_pend_cycles >= 0) chk({tag, "_busy_cycles"}, n, exp_pend_cycles);
        chk({tag, "_sb_nonempty"}, exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, "_gen"}, cfg_gen, e.gen);
            tick();
            chk({tag, "_cons"},  cons,     e.cons);
            chk({tag, "_sel"},   sel,      e.sel);
            chk({tag, "_rel"},   rel_op,   e.rel);
            chk({tag, "_arith"}, arith_op, e.arith);
            cur = e;
        end
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0;
        commit = 1'b0; pkt_valid = 1'b0;
        m = '0; cur = '0;
        tick(); tick();
        rst = 1'b0;

        chk("rst_cons", cons, '0);
        chk("rst_sel", sel, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_gen", cfg_gen, 8'd0);
        chk("rst_ready", cfg_ready, 1'b1);

        // Minimum-latency commit.
        wr(0, 32'hDEADBEEF);
        commit = 1'b1; pkt_valid = 1'b0;
        push_commit();
        tick();
        commit = 1'b0;
        chk("t1_busy_set", busy, 1'b1);
        finish_commit("t1", 1);
        chk("t1_cons0", cons[31:0], 32'hDEADBEEF);
        chk("t1_gen1", cfg_gen, 8'd1);

        // Commit held off by in-flight packets.
        wr(20, 32'h3);
        commit = 1'b1; pkt_valid = 1'b1;
        push_commit();
        tick();
        commit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t2_ready_low", cfg_ready, 1'b0);
            chk("t2_sel_hold", sel[1:0], 2'd0);
            tick();
        end
        pkt_valid = 1'b0;
        finish_commit("t2", 1);
        chk("t2_sel0", sel[1:0], 2'd3);
        chk("t2_gen2", cfg_gen, 8'd2);

        // Last arithmetic opcode, upper data bits ignored.
        wr(67, 32'hFFFFFFFF);
        commit = 1'b1;
        push_commit();
        tick();
        commit = 1'b0;
        finish_commit("t3", 1);
        chk("t3_arith", arith_op, 8'h80);

        // Out-of-range write is dropped and sets the sticky error.
        wr(100, 32'd5);
        chk("t4_err_set", err, 1'b1);
        commit = 1'b1;
        push_commit();
        tick();
        commit = 1'b0;
        finish_commit("t4", 1);
        chk("t4_err_sticky", err, 1'b1);

        // Write with commit in the same cycle, plus a redundant commit while pending.
        cfg_valid = 1'b1; cfg_addr = 7'd1; cfg_data = 32'd7;
        model_write(1, 32'd7);
        commit = 1'b1; pkt_valid = 1'b1;
        push_commit();
        tick();
        cfg_valid = 1'b0;
        pkt_valid = 1'b0;
        tick();
        commit = 1'b0;
        finish_commit("t5", -1);
        chk("t5_cons1", cons[63:32], 32'd7);
        tick(); tick();
        chk("t5_no_requeue_busy", busy, 1'b0);
        chk("t5_gen_once", cfg_gen, m.gen);

        // Drive the generation counter around to zero.
        while (m.gen != 8'd0) begin
            commit = 1'b1;
            push_commit();
            tick();
            commit = 1'b0;
            finish_commit("wrap", 1);
        end
        chk("wrap_gen0", cfg_gen, 8'd0);
        chk("wrap_err_still", err, 1'b1);

        // Reset while a commit is pending aborts it.
        rst = 1'b1; tick(); rst = 1'b0;
        wr(2, 32'h1234);
        commit = 1'b1; pkt_valid = 1'b1;
        tick();
        commit = 1'b0;
        chk("rp_busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0; pkt_valid = 1'b0;
        tick(); tick();
        chk("rp_cons", cons, '0);
        chk("rp_busy_clr", busy, 1'b0);
        chk("rp_ready", cfg_ready, 1'b1);
        chk("rp_gen", cfg_gen, 8'd0);
        chk("rp_err_clr", err, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/atom_config_loader.md
Name: atom_config_loader

Overview:
- Upstream configuration stage for the paired stateful atom.
- Accepts word-serial writes of the atom's constants, mux selects, relational opcodes and arithmetic opcodes into a shadow bank.
- On a commit request, copies the shadow bank to an active bank only in a cycle with no packet in flight.
- The active bank drives the atom's configuration inputs directly, so a packet never sees a half-updated configuration.

Parameters:
- NUM_CONS, 20, number of 32-bit constant words.
- NUM_SEL, 36, number of select fields; 2 bits each; 1-bit selects use bit 0.
- NUM_REL, 4, number of 2-bit relational opcodes.
- NUM_ARITH, 8, number of 1-bit arithmetic opcodes.
- ADDR_W, 7, config address width; must cover NUM_CONS+NUM_SEL+NUM_REL+NUM_ARITH words (68).

Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous reset, active-high.
- i__cfg_valid, in, 1, config write request.
- o__cfg_ready, out, 1, loader can accept a write this cycle.
- i__cfg_addr, in, ADDR_W, config word address.
- i__cfg_data, in, 32, config word data.
- i__commit, in, 1, single-cycle request to publish the shadow bank.
- i__pkt_valid, in, 1, a packet is presented to the atom this cycle.
- o__cons, out, NUM_CONS*32, active constants; word k at bits [32k+31:32k].
- o__sel, out, NUM_SEL*2, active selects; field k at bits [2k+1:2k].
- o__rel_op, out, NUM_REL*2, active relational opcodes.
- o__arith_op, out, NUM_ARITH, active arithmetic opcodes.
- o__busy, out, 1, commit pending (state PEND).
- o__err, out, 1, sticky flag: an out-of-range address was written.
- o__cfg_gen, out, 8, count of completed commits.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values (next edge with rst=1):
  - Shadow and active banks all 0.
  - State IDLE; o__busy=0; o__err=0; o__cfg_gen=0; o__cfg_ready=1.
  - Reset during PEND aborts the commit; active bank stays 0.
- Address map:
  - 0..NUM_CONS-1: constants, full 32 bits.
  - Next NUM_SEL addresses: selects, data[1:0].
  - Next NUM_REL addresses: relational opcodes, data[1:0].
  - Next NUM_ARITH addresses: arithmetic opcodes, data[0].
  - Upper data bits are ignored.
- Write accept: a write is accepted on a clock edge where i__cfg_valid & o__cfg_ready. The shadow word updates at that edge.
- Out-of-range write: address >= 68 with the default parameters.
  - Accepted but dropped; shadow unchanged.
  - o__err sets the next cycle and is cleared only by rst.
- o__cfg_ready = (state != PEND). Writes stall for the whole of a pending commit.
- State machine:
  - IDLE: accepted write -> LOAD. i__commit -> PEND (republishes the current shadow).
  - LOAD: accepted write -> stay in LOAD. i__commit -> PEND.
  - PEND, i__pkt_valid=1: wait; active bank unchanged.
  - PEND, i__pkt_valid=0: at that edge, active <= shadow, o__cfg_gen <= o__cfg_gen+1 (wraps 255->0), next state IDLE.
- Simultaneous write and commit in one cycle: the write is accepted and lands in the shadow bank, and is included in the commit.
- i__commit while in PEND is ignored; it is neither queued nor counted.
- Commit in a cycle with i__pkt_valid=0 still goes to PEND first. The swap happens at the earliest on the following edge, so minimum commit-to-swap is 2 edges.
- Outputs:
  - All outputs are registered.
  - Active values appear the cycle after the swap edge.
  - The atom registers its inputs again, so new configuration reaches the atom's datapath one further cycle later.
- The shadow bank is never visible on outputs; only commits change the active bank.

Optional Feature:
- Macro: ATOM_CFG_READBACK_EN.
- With the macro defined:
  - Adds input i__rd_addr (ADDR_W) and output o__rd_data (32).
  - o__rd_data returns the shadow word at i__rd_addr one cycle later, zero-extended.
  - Returns 0 for out-of-range addresses and 0 under reset.
  - A read and a write to the same address in the same cycle return the old value.
- Without the macro: neither port exists and there is no read mux.

Test Plan:
- Reset, then write addr 0 = 0xDEADBEEF and commit with i__pkt_valid=0 -> o__cons[31:0]=0xDEADBEEF 3 cycles after the commit cycle; o__cfg_gen=1; o__busy high exactly 1 cycle.
- Write addr 20 = 0x3 (sel_1), then commit with i__pkt_valid held 1 for 5 cycles -> o__sel[1:0] stays 0 and o__cfg_ready=0 throughout; updates to 3 after pkt_valid drops; gen increments once.
- Write addr 67 = 0xFFFFFFFF and commit -> o__arith_op[7]=1, other arith bits 0.
- Write addr 100 = 5 -> o__err=1 and stays 1; commit -> active bank unchanged; rst clears o__err.
- Write addr 1 = 7 in the same cycle as i__commit, then a second i__commit during PEND -> o__cons[63:32]=7 after swap; o__cfg_gen advances by 1 only.
- Perform 256 commits -> o__cfg_gen wraps to 0. Assert rst in PEND -> active bank stays 0, state IDLE.
